flow_node_rr: RTL and testbench

Parametrised flow-graph node front end: it replaces the fixed 4-input arbitration and 4-way fan-out of the current node with NUM_IN buffered inputs and NUM_OUT destinations. Each input has its own FIFO. A fair round-robin arbiter selects one head word per cycle, and the word is routed to the destination selected by a field in its control word. Unicast and broadcast are both supported, as are per-destination backpressure and a saturating drop counter. The block sits between the upstream node outputs and the selector/lookup stage of a flow-table node.

---
 rtl/flow_node_rr.sv | 166 ++++++++++++++++
 tb/tb_flow_node_rr.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flow_node_rr.sv
// flow_node_rr: NUM_IN buffered inputs, round-robin arbitration, and routing
// of the granted head word to one destination or to all of them.
module flow_node_rr #(
  parameter int DATA_WIDTH = 480,
  parameter int CTRL_WIDTH = 32,
  parameter int NUM_IN     = 4,
  parameter int NUM_OUT    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int DEST_LSB   = 0,
  parameter int BCAST_BIT  = 31
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_IN-1:0]             in_wr,
  input  logic [NUM_IN*CTRL_WIDTH-1:0]  in_ctl,
  input  logic [NUM_IN*DATA_WIDTH-1:0]  in_data,
  output logic [NUM_IN-1:0]             in_rdy,
  input  logic [NUM_OUT-1:0]            out_rdy,
  output logic [NUM_OUT-1:0]            out_wr,
  output logic [CTRL_WIDTH-1:0]         out_ctl,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(NUM_IN)-1:0]     out_src,
  output logic [15:0]                   drop_cnt
);

  localparam int DW = $clog2(NUM_OUT);
  localparam int SW = $clog2(NUM_IN);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int NW = $clog2(NUM_IN + 1);

  typedef struct packed {
    logic [CTRL_WIDTH-1:0] ctl;
    logic [DATA_WIDTH-1:0] data;
  } word_t;

  word_t           mem    [NUM_IN][FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr [NUM_IN];
  logic [AW-1:0]   wr_ptr [NUM_IN];
  logic [CW-1:0]   count  [NUM_IN];
  word_t           head   [NUM_IN];

  logic [NUM_IN-1:0]  full;
  logic [NUM_IN-1:0]  push;
  logic [NUM_IN-1:0]  pop;
  logic [NUM_IN-1:0]  drop;
  logic [NUM_IN-1:0]  elig;

  logic               grant_vld;
  logic [SW-1:0]      grant_idx;
  logic [SW-1:0]      last_grant;
  logic [SW:0]        cand;
  word_t              grant_word;
  logic [NUM_OUT-1:0] grant_wr;

  logic [NW-1:0]      drop_num;
  logic [16:0]        drop_sum;

  // Ready is a pure function of the registered count, so a write to a full
  // FIFO is dropped even when that FIFO pops in the same cycle.
  assign in_rdy = ~full;

  // FIFO status, write/drop qualification and head-of-line eligibility
  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // otherwise a path that skips the assignment infers a latch.
    full = '0;
    push = '0;
    drop = '0;
    elig = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      head[i] = mem[i][rd_ptr[i]];
      full[i] = (count[i] == CW'(FIFO_DEPTH));
      push[i] = in_wr[i] && !full[i];
      drop[i] = in_wr[i] && full[i];
      if (count[i] != '0) begin
        if (head[i].ctl[BCAST_BIT]) elig[i] = &out_rdy;
        else                        elig[i] = out_rdy[head[i].ctl[DEST_LSB +: DW]];
      end
    end
  end

  // Round-robin search starting one past the last granted channel
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      cand = {1'b0, last_grant} + (SW+1)'(k);
      if (cand >= (SW+1)'(NUM_IN)) cand = cand - (SW+1)'(NUM_IN);
      if (!grant_vld && elig[cand[SW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[SW-1:0];
      end
    end
  end

  // Destination decode of the granted word, pop strobe and drop accounting
  always_comb begin
    grant_word = head[grant_idx];
    grant_wr   = '0;
    if (grant_word.ctl[BCAST_BIT]) grant_wr = '1;
    else                           grant_wr[grant_word.ctl[DEST_LSB +: DW]] = 1'b1;

    pop = '0;
    if (grant_vld) pop[grant_idx] = 1'b1;

    drop_num = '0;
    for (int i = 0; i < NUM_IN; i++) drop_num = drop_num + NW'(drop[i]);
    // 17 bits cannot overflow: at most 0xFFFF + NUM_IN.
    drop_sum = 17'(drop_cnt) + 17'(drop_num);
  end

  // FIFO storage writes
  // NOTE: the storage array has no reset; emptiness is tracked by the
  // pointers and counts, so stale contents are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_IN; i++) begin
      if (!rst && push[i]) begin
        mem[i][wr_ptr[i]] <= {in_ctl[i*CTRL_WIDTH +: CTRL_WIDTH],
                              in_data[i*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
  end

  // FIFO pointers and occupancy counts
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge regardless of block order.
    if (rst) begin
      for (int i = 0; i < NUM_IN; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  end

  // Arbitration pointer, registered output port and saturating drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= SW'(NUM_IN - 1);
      out_wr     <= '0;
      out_ctl    <= '0;
      out_data   <= '0;
      out_src    <= '0;
      drop_cnt   <= '0;
    end else begin
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      out_wr   <= grant_vld ? grant_wr : '0;
      if (grant_vld) begin
        last_grant <= grant_idx;
        out_ctl    <= grant_word.ctl;
        out_data   <= grant_word.data;
        out_src    <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_flow_node_rr.sv
// Self-checking bench for flow_node_rr: directed scenarios plus random
// traffic, compared through a scoreboard against a queue-based model.
module tb_flow_node_rr;

  localparam int DATA_WIDTH = 64;
  localparam int CTRL_WIDTH = 32;
  localparam int NUM_IN     = 4;
  localparam int NUM_OUT    = 4;
  localparam int FIFO_DEPTH = 4;

  logic                          clk;
  logic                          rst;
  logic [NUM_IN-1:0]             in_wr;
  logic [NUM_IN*CTRL_WIDTH-1:0]  in_ctl;
  logic [NUM_IN*DATA_WIDTH-1:0]  in_data;
  logic [NUM_IN-1:0]             in_rdy;
  logic [NUM_OUT-1:0]            out_rdy;
  logic [NUM_OUT-1:0]            out_wr;
  logic [CTRL_WIDTH-1:0]         out_ctl;
  logic [DATA_WIDTH-1:0]         out_data;
  logic [1:0]                    out_src;
  logic [15:0]                   drop_cnt;

  flow_node_rr #(
    .DATA_WIDTH(DATA_WIDTH), .CTRL_WIDTH(CTRL_WIDTH), .NUM_IN(NUM_IN),
    .NUM_OUT(NUM_OUT), .FIFO_DEPTH(FIFO_DEPTH), .DEST_LSB(0), .BCAST_BIT(31)
  ) dut (
    .clk(clk), .rst(rst), .in_wr(in_wr), .in_ctl(in_ctl), .in_data(in_data),
    .in_rdy(in_rdy), .out_rdy(out_rdy), .out_wr(out_wr), .out_ctl(out_ctl),
    .out_data(out_data), .out_src(out_src), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ctl;
    logic [63:0] data;
  } word_t;

  typedef struct packed {
    logic [3:0]  wr;
    logic [31:0] ctl;
    logic [63:0] data;
    logic [1:0]  src;
  } exp_t;

  // Reference model state: one queue per channel plus the expected output.
  word_t q [NUM_IN][$];
  int    last_g;
  int    m_drop;
  exp_t  m_out;
  exp_t  sb [$];
  exp_t  mon_e;
  bit    mon_en = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the rules of one clock edge to the model, using the inputs the DUT saw.
  task automatic model_edge();
    int    grant;
    int    sz [NUM_IN];
    int    ndrop;
    int    c;
    bit    ok;
    word_t h;
    if (rst) begin
      for (int i = 0; i < NUM_IN; i++) q[i].delete();
      last_g = NUM_IN - 1;
      m_drop = 0;
      m_out  = '0;
    end else begin
      grant = -1;
      for (int k = 1; k <= NUM_IN; k++) begin
        c = (last_g + k) % NUM_IN;
        if (grant < 0 && q[c].size() > 0) begin
          h  = q[c][0];
          ok = h.ctl[31] ? (out_rdy == 4'hF) : out_rdy[h.ctl[1:0]];
          if (ok) grant = c;
        end
      end
      for (int i = 0; i < NUM_IN; i++) sz[i] = q[i].size();
      if (grant >= 0) begin
        h          = q[grant].pop_front();
        m_out.wr   = h.ctl[31] ? 4'hF : (4'b0001 << h.ctl[1:0]);
        m_out.ctl  = h.ctl;
        m_out.data = h.data;
        m_out.src  = 2'(grant);
        last_g     = grant;
      end else begin
        m_out.wr = 4'h0;
      end
      ndrop = 0;
      for (int i = 0; i < NUM_IN; i++) begin
        if (in_wr[i]) begin
          if (sz[i] == FIFO_DEPTH) ndrop++;
          else q[i].push_back({in_ctl[i*32 +: 32], in_data[i*64 +: 64]});
        end
      end
      m_drop = (m_drop + ndrop > 65535) ? 65535 : m_drop + ndrop;
    end
    sb.push_back(m_out);
  endtask

  // Monitor: each cycle the DUT presents exactly one expected output state.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'd0, 64'd1);
      end else begin
        mon_e = sb.pop_front();
        check("out_wr",   out_wr,   mon_e.wr);
        check("out_ctl",  out_ctl,  mon_e.ctl);
        check("out_data", out_data, mon_e.data);
        check("out_src",  out_src,  mon_e.src);
        for (int i = 0; i < NUM_IN; i++)
          check("in_rdy", in_rdy[i], (q[i].size() != FIFO_DEPTH));
        check("drop_cnt", drop_cnt, 64'(m_drop));
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_edge();
    mon_en = 1'b1;
    #1;
  endtask

  task automatic clear_in();
    in_wr = '0;
  endtask

  task automatic wr_ch(input int ch, input logic [31:0] ctl, input logic [63:0] data);
    in_wr[ch]           = 1'b1;
    in_ctl[ch*32 +: 32] = ctl;
    in_data[ch*64 +: 64] = data;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  logic [63:0] d0;
  logic [31:0] rc;

  initial begin
    rst = 1'b1; in_wr = '0; in_ctl = '0; in_data = '0; out_rdy = 4'hF;
    cycle(); cycle();
    rst = 1'b0;
    check("reset_in_rdy", in_rdy, 4'hF);
    check("reset_out_wr", out_wr, 4'h0);
    check("reset_drop",   drop_cnt, 16'h0);

    // Single unicast word, two-cycle latency
    d0 = 64'hDEAD_BEEF_0123_4567;
    wr_ch(0, 32'h0000_0002, d0);
    cycle();
    clear_in();
    cycle();
    check("t1_out_wr",   out_wr,   4'b0100);
    check("t1_out_src",  out_src,  2'd0);
    check("t1_out_data", out_data, d0);
    check("t1_out_ctl",  out_ctl,  32'h0000_0002);
    repeat (3) cycle();

    // All channels streaming to dest 0 while honouring in_rdy
    repeat (40) begin
      for (int i = 0; i < NUM_IN; i++) begin
        in_wr[i] = in_rdy[i];
        in_ctl[i*32 +: 32] = 32'h0;
        in_data[i*64 +: 64] = rnd64();
      end
      cycle();
    end
    clear_in();
    check("t2_no_drops", drop_cnt, 16'h0);
    repeat (20) cycle();

    // Backpressure on dest 1: fill, overflow, then release
    out_rdy = 4'b1101;
    for (int n = 0; n < 7; n++) begin
      wr_ch(0, 32'h0000_0001, 64'(n + 100));
      cycle();
      if (n == 3) check("t3_full", in_rdy[0], 1'b0);
    end
    clear_in();
    check("t3_drops",  drop_cnt, 16'd3);
    check("t3_held",   out_wr,   4'h0);
    out_rdy = 4'hF;
    cycle();
    check("t3_first_out", out_wr,    4'b0010);
    check("t3_rdy_back",  in_rdy[0], 1'b1);
    repeat (6) cycle();

    // Broadcast held until all destinations ready; unicast passes it
    out_rdy = 4'b1110;
    wr_ch(0, 32'h8000_0000, 64'hB0B0);
    cycle();
    clear_in();
    wr_ch(1, 32'h0000_0002, 64'hC1C1);
    cycle();
    clear_in();
    cycle();
    check("t4_uni_wr",  out_wr,  4'b0100);
    check("t4_uni_src", out_src, 2'd1);
    out_rdy = 4'hF;
    cycle();
    check("t4_bc_wr",  out_wr,  4'hF);
    check("t4_bc_src", out_src, 2'd0);
    repeat (4) cycle();

    // Drop counter saturation
    out_rdy = 4'h0;
    in_wr   = 4'hF;
    while (m_drop < 16'hFFF0) cycle();
    in_wr = 4'b0001;
    while (m_drop < 16'hFFFE) cycle();
    check("t5_pre_sat", drop_cnt, 16'hFFFE);
    in_wr = 4'hF;
    cycle();
    check("t5_sat", drop_cnt, 16'hFFFF);
    cycle(); cycle();
    check("t5_no_wrap", drop_cnt, 16'hFFFF);
    clear_in();

    // Reset with words buffered
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    wr_ch(0, 32'h1, 64'h11); wr_ch(1, 32'h2, 64'h22); wr_ch(2, 32'h3, 64'h33);
    cycle();
    clear_in();
    rst = 1'b1;
    out_rdy = 4'hF;
    wr_ch(3, 32'h0, 64'h44);
    cycle();
    clear_in();
    rst = 1'b0;
    check("t6_out_wr",   out_wr,   4'h0);
    check("t6_out_ctl",  out_ctl,  32'h0);
    check("t6_out_data", out_data, 64'h0);
    check("t6_out_src",  out_src,  2'd0);
    check("t6_in_rdy",   in_rdy,   4'hF);
    check("t6_drop",     drop_cnt, 16'h0);
    repeat (6) cycle();

    // Random traffic
    repeat (3000) begin
      rst = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < NUM_IN; i++) begin
        in_wr[i] = $urandom_range(0, 1);
        rc = $urandom;
        rc[31] = ($urandom_range(0, 7) == 0);
        in_ctl[i*32 +: 32] = rc;
        in_data[i*64 +: 64] = rnd64();
      end
      for (int j = 0; j < NUM_OUT; j++) out_rdy[j] = ($urandom_range(0, 3) != 0);
      cycle();
    end
    rst = 1'b0;
    clear_in();
    out_rdy = 4'hF;
    repeat (20) cycle();
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
